// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS front end and the control unit.
//   - fetch_state_e    : fetch sequencer state encoding
//   - RESET_PC_DEFAULT : text segment base that the PC loads on reset
//   - OP_*             : primary opcode constants (Instruction[31:26])
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/next_pc_logic.sv
// next_pc_logic: purely combinational next-PC selection.
//   pc_4        in  : address of the held instruction + 4
//   instr_index in  : Instruction[25:0] (jump index; [15:0] is the branch immediate)
//   jr_target   in  : rs register value for JR
//   jr, jump, branch_eq, branch_ne, zero in : control unit outputs and ALU zero
//   next_pc     out : selected next PC
//   misaligned  out : next_pc is not word aligned
module next_pc_logic #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc_4,
  input  logic [25:0]           instr_index,
  input  logic [ADDR_WIDTH-1:0] jr_target,
  input  logic                  jr,
  input  logic                  jump,
  input  logic                  branch_eq,
  input  logic                  branch_ne,
  input  logic                  zero,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  misaligned
);

  logic [ADDR_WIDTH-1:0] branch_offset;
  logic                  branch_taken;

  // Sign-extended word offset; the add below wraps modulo 2^ADDR_WIDTH.
  assign branch_offset = {{(ADDR_WIDTH-18){instr_index[15]}}, instr_index[15:0], 2'b00};
  assign branch_taken  = (branch_eq & zero) | (branch_ne & ~zero);

  always_comb begin
    if (jr) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = {pc_4[ADDR_WIDTH-1:28], instr_index, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_4 + branch_offset;
    end else begin
      next_pc = pc_4;
    end
  end

  // Only a JR target can be misaligned; jump/branch targets end in 2'b00.
  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: MIPS instruction-fetch stage. Owns the PC, fetches one
// instruction at a time over a req/ack handshake, holds it for decode and
// selects the next PC when the datapath retires it.
//   clk, reset (async, active low)
//   imem_req/imem_addr out, imem_ack/imem_rdata in : instruction memory port
//   Instruction, InstrValid, PC, PC_4 out          : held instruction to decode
//   ExecDone, Jump, JR, BranchEQ, BranchNE, Zero, JRTarget in : retire + redirect
//   AddrError out                                  : sticky misaligned-target flag
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           Instruction,
  output logic                  InstrValid,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [ADDR_WIDTH-1:0] PC_4,
  input  logic                  ExecDone,
  input  logic                  Jump,
  input  logic                  JR,
  input  logic                  BranchEQ,
  input  logic                  BranchNE,
  input  logic                  Zero,
  input  logic [ADDR_WIDTH-1:0] JRTarget,
  output logic                  AddrError
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_4_q, pc_4_d;
  logic [31:0]           instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  misaligned;

  next_pc_logic #(.ADDR_WIDTH(ADDR_WIDTH)) u_next_pc (
    .pc_4        (pc_4_q),
    .instr_index (instr_q[25:0]),
    .jr_target   (JRTarget),
    .jr          (JR),
    .jump        (Jump),
    .branch_eq   (BranchEQ),
    .branch_ne   (BranchNE),
    .zero        (Zero),
    .next_pc     (next_pc),
    .misaligned  (misaligned)
  );

  always_comb begin
    // NOTE: every variable gets a hold default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    pc_4_d  = pc_4_q;
    instr_d = instr_q;
    unique case (state_q)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ExecDone) begin
          // A misaligned target is still latched so software can inspect it.
          pc_d    = next_pc;
          pc_4_d  = next_pc + ADDR_WIDTH'(4);
          state_d = misaligned ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RST;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RST;
      pc_q    <= RESET_PC;
      pc_4_q  <= RESET_PC + ADDR_WIDTH'(4);
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc_4_q  <= pc_4_d;
      instr_q <= instr_d;
    end
  end

  // Outputs decode the state register directly, so asserting reset drops
  // imem_req in the same cycle and imem_addr cannot move during a request.
  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign Instruction = instr_q;
  assign InstrValid  = (state_q == ST_ISSUE);
  assign PC          = pc_q;
  assign PC_4        = pc_4_q;
  assign AddrError   = (state_q == ST_HALT);

endmodule
